// File: rtl/bsa_pkg.sv
// ----------------------------------------------------------------------------
// bsa_pkg
// Shared types and helpers for the bit-serial adder/subtractor.
//   bsa_state_e   : control FSM states (IDLE, LOADED, RUN, DONE)
//   bsa_cnt_w()   : bit-counter width for a given operand width
// ----------------------------------------------------------------------------
package bsa_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOADED = 2'd1,
      RUN    = 2'd2,
      DONE   = 2'd3
   } bsa_state_e;

   // Width of a counter able to represent 0..width.
   function automatic int bsa_cnt_w(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/bsa_full_adder.sv
// ----------------------------------------------------------------------------
// bsa_full_adder
// One-bit combinational full adder used as the serial datapath ALU.
//   a_i, b_i  : operand bits
//   cin_i     : carry in
//   s_o       : sum bit
//   cout_o    : carry out
// ----------------------------------------------------------------------------
module bsa_full_adder
   import bsa_pkg::*;
(
   input  logic a_i,
   input  logic b_i,
   input  logic cin_i,
   output logic s_o,
   output logic cout_o
);

   assign s_o    = a_i ^ b_i ^ cin_i;
   assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule

// File: rtl/bit_serial_addsub.sv
// ----------------------------------------------------------------------------
// bit_serial_addsub
// Bit-serial adder/subtractor, one operand bit per clock, LSB first.
// A WIDTH-bit operation takes WIDTH cycles after start; done pulses for one
// cycle when sum_o/cout_o are updated.
//
// Ports:
//   clk_i     : clock, rising edge
//   rst_i     : asynchronous active-high reset
//   load_i    : capture a_i, b_i, sub_i (wins over start_i)
//   start_i   : begin the operation (LOADED) / return to IDLE (DONE)
//   a_i, b_i  : operands, WIDTH bits
//   sub_i     : 0 = A+B, 1 = A-B (A + ~B + 1)
//   sum_o     : registered result, held until next completion or reset
//   cout_o    : final carry out (for subtraction, 1 = no borrow)
//   busy_o    : high while in RUN
//   done_o    : one-cycle completion pulse
//   ovf_o     : signed overflow (only when BSA_OVF_EN is defined)
//
// Optional feature macro: BSA_OVF_EN
// ----------------------------------------------------------------------------
module bit_serial_addsub
   import bsa_pkg::*;
#(
   parameter int WIDTH = 8
)(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             sub_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             cout_o,
   output logic             busy_o,
   output logic             done_o
`ifdef BSA_OVF_EN
   ,output logic            ovf_o
`endif
);

   localparam int CW = bsa_cnt_w(WIDTH);

   bsa_state_e       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             sub_q, sub_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             done_q, done_d;
`ifdef BSA_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   logic fa_s;
   logic fa_c;
   logic last_bit;

   // Single shared full adder; subtraction inverts B here and presets the
   // carry flop to 1 at load time, giving A + ~B + 1.
   bsa_full_adder u_fa (
      .a_i    (a_q[0]),
      .b_i    (b_q[0] ^ sub_q),
      .cin_i  (carry_q),
      .s_o    (fa_s),
      .cout_o (fa_c)
   );

   // The MSB is processed on the same edge that publishes the result, so
   // completion is taken from the adder output rather than a later cycle.
   assign last_bit = (cnt_q == CW'(WIDTH - 1));

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sub_q   <= 1'b0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef BSA_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sub_q   <= sub_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         done_q  <= done_d;
`ifdef BSA_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   // ------------------------------------------------------------------
   // Next-state and datapath
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sub_d   = sub_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      done_d  = 1'b0;
`ifdef BSA_OVF_EN
      ovf_d   = ovf_q;
`endif

      case (state_q)
         IDLE, LOADED, DONE: begin
            if (load_i) begin
               // load has priority over start in every non-RUN state
               a_d     = a_i;
               b_d     = b_i;
               sub_d   = sub_i;
               carry_d = sub_i;
               cnt_d   = '0;
               state_d = LOADED;
            end else if (start_i) begin
               if (state_q == LOADED) begin
                  state_d = RUN;
               end else if (state_q == DONE) begin
                  state_d = IDLE;
               end
            end
         end

         RUN: begin
            // load/start are ignored here; the operation runs to completion
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            res_d   = {fa_s, res_q[WIDTH-1:1]};
            carry_d = fa_c;
            cnt_d   = cnt_q + CW'(1);
            if (last_bit) begin
               sum_d   = {fa_s, res_q[WIDTH-1:1]};
               cout_d  = fa_c;
               done_d  = 1'b1;
               state_d = DONE;
`ifdef BSA_OVF_EN
               // carry into the MSB is the carry flop at this point
               ovf_d   = carry_q ^ fa_c;
`endif
            end
         end

         default: state_d = IDLE;
      endcase
   end

   assign sum_o  = sum_q;
   assign cout_o = cout_q;
   assign busy_o = (state_q == RUN);
   assign done_o = done_q;
`ifdef BSA_OVF_EN
   assign ovf_o  = ovf_q;
`endif

endmodule

// File: tb/tb_bit_serial_addsub.sv
// ----------------------------------------------------------------------------
// tb_bit_serial_addsub
// Two instances (WIDTH=4 and WIDTH=8) share clock and reset. An arithmetic
// reference model tracks the expected outputs of each instance and a
// compare process checks them every falling edge; directed sequences add
// hand-computed literal expectations.
// ----------------------------------------------------------------------------
module tb_bit_serial_addsub;

   logic        clk = 1'b0;
   logic        rst;
   logic        ld [2];
   logic        st [2];
   logic        sb [2];
   logic [63:0] av [2];
   logic [63:0] bv [2];

   logic [3:0]  sum4;
   logic [7:0]  sum8;
   logic        co [2];
   logic        by [2];
   logic        dn [2];
`ifdef BSA_OVF_EN
   logic        ov [2];
`endif

   int n_checks = 0;
   int n_err    = 0;
   int done_cnt [2];

   always #5 clk = ~clk;

   bit_serial_addsub #(.WIDTH(4)) u_w4 (
      .clk_i   (clk),
      .rst_i   (rst),
      .load_i  (ld[0]),
      .start_i (st[0]),
      .a_i     (av[0][3:0]),
      .b_i     (bv[0][3:0]),
      .sub_i   (sb[0]),
      .sum_o   (sum4),
      .cout_o  (co[0]),
      .busy_o  (by[0]),
      .done_o  (dn[0])
`ifdef BSA_OVF_EN
      ,.ovf_o  (ov[0])
`endif
   );

   bit_serial_addsub #(.WIDTH(8)) u_w8 (
      .clk_i   (clk),
      .rst_i   (rst),
      .load_i  (ld[1]),
      .start_i (st[1]),
      .a_i     (av[1][7:0]),
      .b_i     (bv[1][7:0]),
      .sub_i   (sb[1]),
      .sum_o   (sum8),
      .cout_o  (co[1]),
      .busy_o  (by[1]),
      .done_o  (dn[1])
`ifdef BSA_OVF_EN
      ,.ovf_o  (ov[1])
`endif
   );

   // ------------------------------------------------------------------
   // Helpers
   // ------------------------------------------------------------------
   function automatic int wid(input int k);
      return (k == 0) ? 4 : 8;
   endfunction

   function automatic logic [63:0] dsum(input int k);
      return (k == 0) ? {60'd0, sum4} : {56'd0, sum8};
   endfunction

   // Full-width result of A+B or A-B (two's complement), including carry.
   function automatic logic [63:0] f_full(input logic [63:0] a, input logic [63:0] b,
                                          input logic s, input int w);
      logic [63:0] mask;
      mask = (64'd1 << w) - 64'd1;
      return (a & mask) + (s ? (~b & mask) : (b & mask)) + {63'd0, s};
   endfunction

   function automatic logic f_ovf(input logic [63:0] a, input logic [63:0] b,
                                  input logic s, input int w);
      longint sa, sbv, r, hi, lo;
      sa  = $signed(a << (64 - w));
      sa  = sa >>> (64 - w);
      sbv = $signed(b << (64 - w));
      sbv = sbv >>> (64 - w);
      r   = s ? (sa - sbv) : (sa + sbv);
      hi  = (longint'(1) << (w - 1)) - 1;
      lo  = -(longint'(1) << (w - 1));
      return (r > hi) || (r < lo);
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // ------------------------------------------------------------------
   // Reference model: phase 0 idle, 1 loaded, 3 done; m_left counts the
   // run cycles still to go (nonzero means busy).
   // ------------------------------------------------------------------
   int          m_phase [2];
   int          m_left  [2];
   logic [63:0] m_a     [2];
   logic [63:0] m_b     [2];
   logic        m_sub   [2];
   logic [63:0] m_sum   [2];
   logic        m_cout  [2];
   logic        m_ovf   [2];
   logic        m_done  [2];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 2; k++) begin
            m_phase[k] <= 0;
            m_left[k]  <= 0;
            m_a[k]     <= '0;
            m_b[k]     <= '0;
            m_sub[k]   <= 1'b0;
            m_sum[k]   <= '0;
            m_cout[k]  <= 1'b0;
            m_ovf[k]   <= 1'b0;
            m_done[k]  <= 1'b0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            m_done[k] <= 1'b0;
            if (m_left[k] > 0) begin
               m_left[k] <= m_left[k] - 1;
               if (m_left[k] == 1) begin
                  m_sum[k]   <= f_full(m_a[k], m_b[k], m_sub[k], wid(k)) &
                                ((64'd1 << wid(k)) - 64'd1);
                  m_cout[k]  <= f_full(m_a[k], m_b[k], m_sub[k], wid(k))[wid(k)];
                  m_ovf[k]   <= f_ovf(m_a[k], m_b[k], m_sub[k], wid(k));
                  m_done[k]  <= 1'b1;
                  m_phase[k] <= 3;
               end
            end else if (ld[k]) begin
               m_a[k]     <= av[k];
               m_b[k]     <= bv[k];
               m_sub[k]   <= sb[k];
               m_phase[k] <= 1;
            end else if (st[k]) begin
               if (m_phase[k] == 1)      m_left[k]  <= wid(k);
               else if (m_phase[k] == 3) m_phase[k] <= 0;
            end
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         check($sformatf("busy[%0d]", k), {63'd0, by[k]}, {63'd0, m_left[k] > 0});
         check($sformatf("done[%0d]", k), {63'd0, dn[k]}, {63'd0, m_done[k]});
         check($sformatf("sum[%0d]", k),  dsum(k),         m_sum[k]);
         check($sformatf("cout[%0d]", k), {63'd0, co[k]}, {63'd0, m_cout[k]});
`ifdef BSA_OVF_EN
         check($sformatf("ovf[%0d]", k),  {63'd0, ov[k]}, {63'd0, m_ovf[k]});
`endif
         if (dn[k] === 1'b1) done_cnt[k]++;
      end
   end

   // ------------------------------------------------------------------
   // Directed operation: load, start, bounded wait for done, literal checks
   // ------------------------------------------------------------------
   task automatic run_op(input int k, input logic [63:0] a, input logic [63:0] b,
                         input logic s, input logic [63:0] exp_s, input logic exp_c);
      int n;
      ld[k] = 1'b1; av[k] = a; bv[k] = b; sb[k] = s;
      tick();
      ld[k] = 1'b0; st[k] = 1'b1;
      tick();                      // start sampled on this edge
      st[k] = 1'b0;
      n = 0;
      while (dn[k] !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      check($sformatf("latency[%0d]", k), 64'(n), 64'(wid(k)));
      check($sformatf("lit_sum[%0d]", k), dsum(k), exp_s);
      check($sformatf("lit_cout[%0d]", k), {63'd0, co[k]}, {63'd0, exp_c});
      tick();
      check($sformatf("done_pulse[%0d]", k), {63'd0, dn[k]}, 64'd0);
      check($sformatf("busy_after[%0d]", k), {63'd0, by[k]}, 64'd0);
   endtask

   initial begin
      int n;
      int dc;
      for (int k = 0; k < 2; k++) begin
         ld[k] = 1'b0; st[k] = 1'b0; sb[k] = 1'b0; av[k] = '0; bv[k] = '0;
         done_cnt[k] = 0;
      end
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();

      // reset state
      check("rst_sum4", {60'd0, sum4}, 64'd0);
      check("rst_sum8", {56'd0, sum8}, 64'd0);
      check("rst_busy8", {63'd0, by[1]}, 64'd0);
      check("rst_done4", {63'd0, dn[0]}, 64'd0);

      // start in IDLE is ignored
      st[0] = 1'b1;
      tick();
      st[0] = 1'b0;
      tick();
      check("idle_start_busy4", {63'd0, by[0]}, 64'd0);

      run_op(0, 13, 11, 1'b0, 64'd8, 1'b1);
      run_op(1, 200, 56, 1'b1, 64'd144, 1'b1);
      run_op(1, 5, 7, 1'b1, 64'd254, 1'b0);
      run_op(0, 7, 1, 1'b0, 64'd8, 1'b0);
`ifdef BSA_OVF_EN
      check("lit_ovf_7p1", {63'd0, ov[0]}, 64'd1);
`endif
      run_op(0, 5, 7, 1'b1, 64'd14, 1'b0);
`ifdef BSA_OVF_EN
      check("lit_ovf_5m7", {63'd0, ov[0]}, 64'd0);
`endif

      // load/start during RUN are ignored
      ld[1] = 1'b1; av[1] = 100; bv[1] = 27; sb[1] = 1'b0;
      tick();
      ld[1] = 1'b0; st[1] = 1'b1;
      tick();
      st[1] = 1'b0;
      tick();
      ld[1] = 1'b1; st[1] = 1'b1; av[1] = 1; bv[1] = 1; sb[1] = 1'b1;
      tick();
      ld[1] = 1'b0; st[1] = 1'b0;
      n = 0;
      while (dn[1] !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      check("run_ign_latency", 64'(n), 64'd6);
      check("run_ign_sum", {56'd0, sum8}, 64'd127);
      check("run_ign_cout", {63'd0, co[1]}, 64'd0);
      tick();

      // load+start together in LOADED: load wins, no RUN
      ld[1] = 1'b1; av[1] = 3; bv[1] = 4; sb[1] = 1'b0;
      tick();
      st[1] = 1'b1;
      tick();
      ld[1] = 1'b0; st[1] = 1'b0;
      tick();
      check("ld_st_busy", {63'd0, by[1]}, 64'd0);
      st[1] = 1'b1;
      tick();
      st[1] = 1'b0;
      n = 0;
      while (dn[1] !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      check("ld_st_sum", {56'd0, sum8}, 64'd7);
      tick();

      // reset mid-RUN
      dc = done_cnt[1];
      ld[1] = 1'b1; av[1] = 200; bv[1] = 56; sb[1] = 1'b1;
      tick();
      ld[1] = 1'b0; st[1] = 1'b1;
      tick();
      st[1] = 1'b0;
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_sum", {56'd0, sum8}, 64'd0);
      check("mid_rst_cout", {63'd0, co[1]}, 64'd0);
      check("mid_rst_busy", {63'd0, by[1]}, 64'd0);
      st[1] = 1'b1;
      tick();
      st[1] = 1'b0;
      for (int i = 0; i < 12; i++) tick();
      check("mid_rst_nostart", {63'd0, by[1]}, 64'd0);
      check("mid_rst_nodone", 64'(done_cnt[1]), 64'(dc));

      // back-to-back on WIDTH=4
      dc = done_cnt[0];
      run_op(0, 3, 4, 1'b0, 64'd7, 1'b0);
      run_op(0, 9, 2, 1'b1, 64'd7, 1'b1);
      check("b2b_done_count", 64'(done_cnt[0]), 64'(dc + 2));

      tick();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
